// File: rtl/vec_result_collector.sv
// Packs PACK consecutive signed PE results into one wide word and queues the
// words in a first-word-fall-through FIFO drained over a valid/ready stream.
module vec_result_collector #(
    parameter int W_Y   = 19,
    parameter int PACK  = 4,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W_Y-1:0]        y,
    input  logic                  v_valid,
    input  logic                  flush,
    output logic [PACK*W_Y-1:0]   m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CW-1:0]         count,
    output logic                  overflow
);

    localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0]        idx_q, idx_d;
    logic [PACK*W_Y-1:0]  pack_q, pack_d;
    logic [PACK*W_Y-1:0]  word_d;
    logic                 push;

    logic [PACK*W_Y-1:0]  data_q [DEPTH];
    logic                 last_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 empty, full, pop, wr_en;

    // Packer: the same-cycle result always lands before any flush closes the word.
    always_comb begin
        word_d = pack_q;
        if (v_valid) begin
            word_d[int'(idx_q)*W_Y +: W_Y] = y;
        end
        push = (v_valid && (idx_q == IW'(PACK - 1))) ||
               (flush && ((idx_q != '0) || v_valid));
        if (push) begin
            idx_d  = '0;
            pack_d = '0;
        end else begin
            idx_d  = v_valid ? idx_q + 1'b1 : idx_q;
            pack_d = word_d;
        end
    end

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        pop      = !empty && m_ready;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        wr_en    = push && (!full || pop);
        ovf_d    = ovf_q || (push && full && !pop);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            pack_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            pack_q   <= pack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            data_q[wr_ptr_q] <= word_d;
            last_q[wr_ptr_q] <= flush;
        end
    end

    assign m_valid  = !empty;
    assign m_data   = empty ? '0 : data_q[rd_ptr_q];
    assign m_last   = empty ? 1'b0 : last_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_vec_result_collector.sv
// Self-checking bench for vec_result_collector: a table of cycle vectors plus
// hand-written corner sequences, all cross-checked against a queue scoreboard.
module tb_vec_result_collector;

    localparam int W_Y = 19;
    localparam int PACK = 4;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = PACK * W_Y;

    logic            clk = 1'b0;
    logic            rst;
    logic [W_Y-1:0]  y;
    logic            v_valid;
    logic            flush;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic            m_valid;
    logic            m_ready;
    logic [CW-1:0]   count;
    logic            overflow;

    vec_result_collector #(.W_Y(W_Y), .PACK(PACK), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .y(y), .v_valid(v_valid), .flush(flush),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    typedef struct {
        logic          v;
        int            yv;
        logic          fl;
        logic          rdy;
        int            exp_count;
        logic          exp_valid;
        logic          exp_last;
        logic [DW-1:0] exp_data;
    } vec_t;

    word_t         sb[$];
    int            m_idx;
    logic [DW-1:0] m_word;
    logic          m_ovf;
    int            total = 0;
    int            bad = 0;
    vec_t          tbl[10];

    function automatic logic [DW-1:0] pk(int a, int b, int c, int d);
        logic [W_Y-1:0] la, lb, lc, ld;
        la = W_Y'(a); lb = W_Y'(b); lc = W_Y'(c); ld = W_Y'(d);
        return {ld, lc, lb, la};
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", DW'(m_valid), DW'(sb.size() > 0));
        chk("data", m_data, (sb.size() > 0) ? sb[0].data : '0);
        chk("last", DW'(m_last), DW'((sb.size() > 0) ? sb[0].last : 1'b0));
        chk("count", DW'(count), DW'(sb.size()));
        chk("overflow", DW'(overflow), DW'(m_ovf));
    endtask

    // Drive one cycle at the negedge, advance the reference, check at the next negedge.
    task automatic step(logic r, logic v, int yv, logic fl, logic rdy);
        logic [DW-1:0] w;
        logic full, popd, pushd;
        rst = r; v_valid = v; y = W_Y'(yv); flush = fl; m_ready = rdy;
        if (r) begin
            m_idx = 0; m_word = '0; m_ovf = 1'b0; sb.delete();
        end else begin
            full = (sb.size() == DEPTH);
            popd = (sb.size() > 0) && rdy;
            w = m_word;
            if (v) w[m_idx*W_Y +: W_Y] = W_Y'(yv);
            pushd = (v && m_idx == PACK - 1) || (fl && (m_idx != 0 || v));
            if (popd) void'(sb.pop_front());
            if (pushd) begin
                if (full && !popd) m_ovf = 1'b1;
                else sb.push_back({fl, w});
                m_word = '0; m_idx = 0;
            end else begin
                m_word = w;
                if (v) m_idx++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic push_word(int base, logic rdy_last);
        for (int i = 0; i < PACK; i++)
            step(0, 1, base + i, 0, (i == PACK - 1) ? rdy_last : 1'b0);
    endtask

    initial begin
        m_idx = 0; m_word = '0; m_ovf = 1'b0;
        rst = 1; y = '0; v_valid = 0; flush = 0; m_ready = 0;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        chk("reset_valid", DW'(m_valid), '0);
        chk("reset_data", m_data, '0);

        // Tests 1 and 3 as a vector table.
        tbl[0] = '{1, 1,  0, 0, 0, 0, 0, '0};
        tbl[1] = '{1, -2, 0, 0, 0, 0, 0, '0};
        tbl[2] = '{1, 3,  0, 0, 0, 0, 0, '0};
        tbl[3] = '{1, -4, 0, 0, 1, 1, 0, pk(1, -2, 3, -4)};
        tbl[4] = '{0, 0,  1, 0, 1, 1, 0, pk(1, -2, 3, -4)};
        tbl[5] = '{1, 5,  0, 0, 1, 1, 0, pk(1, -2, 3, -4)};
        tbl[6] = '{1, 6,  0, 0, 1, 1, 0, pk(1, -2, 3, -4)};
        tbl[7] = '{0, 0,  1, 0, 2, 1, 0, pk(1, -2, 3, -4)};
        tbl[8] = '{0, 0,  0, 1, 1, 1, 1, pk(5, 6, 0, 0)};
        tbl[9] = '{0, 0,  0, 1, 0, 0, 0, '0};
        for (int i = 0; i < 10; i++) begin
            step(0, tbl[i].v, tbl[i].yv, tbl[i].fl, tbl[i].rdy);
            chk($sformatf("tbl%0d_count", i), DW'(count), DW'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_valid", i), DW'(m_valid), DW'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_last", i), DW'(m_last), DW'(tbl[i].exp_last));
            chk($sformatf("tbl%0d_data", i), m_data, tbl[i].exp_data);
        end
        step(0, 0, 0, 1, 0);
        chk("idle_flush_count", DW'(count), '0);

        // Test 2: extreme values keep exact bit patterns.
        step(0, 1, -262144, 0, 0);
        step(0, 1, 262143, 0, 0);
        step(0, 1, 7, 0, 0);
        step(0, 1, -1, 0, 0);
        chk("min_lane0", DW'(m_data[18:0]), DW'(19'h40000));
        chk("max_lane1", DW'(m_data[37:19]), DW'(19'h3FFFF));
        chk("ext_word", m_data, pk(-262144, 262143, 7, -1));
        step(0, 0, 0, 0, 1);

        // Test 5: full FIFO, push and pop together.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) push_word(100 + 10 * k, 0);
        chk("full_count", DW'(count), DW'(DEPTH));
        push_word(900, 1);
        chk("pp_count", DW'(count), DW'(DEPTH));
        chk("pp_ovf", DW'(overflow), '0);
        for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 0, 1);
        chk("pp_drained", DW'(count), '0);

        // Test 4: overflow on the ninth word, stall held stable, then drain.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH + 1; k++) push_word(200 + 10 * k, 0);
        chk("ovf_count", DW'(count), DW'(DEPTH));
        chk("ovf_flag", DW'(overflow), 1);
        chk("ovf_head", m_data, pk(200, 201, 202, 203));
        step(0, 0, 0, 0, 0);
        chk("stall_hold", m_data, pk(200, 201, 202, 203));
        for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 0, 1);
        chk("ovf_drained", DW'(count), '0);
        chk("ovf_sticky", DW'(overflow), 1);

        // Test 6: reset mid-word with words queued.
        for (int k = 0; k < 3; k++) push_word(300 + 10 * k, 0);
        step(0, 1, 11, 0, 0);
        step(0, 1, 12, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_valid", DW'(m_valid), '0);
        chk("rst_count", DW'(count), '0);
        chk("rst_ovf", DW'(overflow), '0);
        for (int i = 0; i < PACK; i++) step(0, 1, 41 + i, 0, 0);
        chk("fresh_word", m_data, pk(41, 42, 43, 44));
        chk("fresh_count", DW'(count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
